// File: rtl/pc_counter_sequencer_if.sv
// ------------------------------------------------------------------
// pc_counter_sequencer_if: request/counter bus for the PC sequencer.
// Rev 1.0
// ------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface pc_counter_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             clr_req;
  logic             jmp_req;
  logic [WIDTH-1:0] jmp_addr;
  logic             inc_req;
  logic             oe_req;
  logic             busy;
  logic             done;
  logic             ctr_cclr_bar;
  logic             ctr_cload_bar;
  logic             ctr_ccken;
  logic             ctr_rcken_bar;
  logic [WIDTH-1:0] ctr_din;
  logic             ctr_g;
  logic             ctr_g_bar;
  logic             ctr_rco_bar;
  logic [WIDTH-1:0] shadow_pc;
  logic             wrap_flag;
  logic             rco_err;

  // Control unit plus the counter chip.
  modport master (
    output clr_req, jmp_req, jmp_addr, inc_req, oe_req, ctr_rco_bar,
    input  busy, done, ctr_cclr_bar, ctr_cload_bar, ctr_ccken, ctr_rcken_bar,
    input  ctr_din, ctr_g, ctr_g_bar, shadow_pc, wrap_flag, rco_err
  );

  modport slave (
    input  clr_req, jmp_req, jmp_addr, inc_req, oe_req, ctr_rco_bar,
    output busy, done, ctr_cclr_bar, ctr_cload_bar, ctr_ccken, ctr_rcken_bar,
    output ctr_din, ctr_g, ctr_g_bar, shadow_pc, wrap_flag, rco_err
  );
endinterface

`default_nettype wire

// File: rtl/pc_counter_sequencer.sv
// ------------------------------------------------------------------
// pc_counter_sequencer: sequences clear/jump/increment on a loadable counter.
// Rev 1.0
// ------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module pc_counter_sequencer #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  reset_bar,
  pc_counter_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_LOADR  = 3'd2,
    S_XFER   = 3'd3,
    S_INC    = 3'd4,
    S_SETTLE = 3'd5
  } state_t;

  localparam int            C_CW          = 4;
  localparam logic [C_CW-1:0] C_SETTLE_LAST = C_CW'(SETTLE - 1);
  localparam logic [WIDTH-1:0] C_ONE        = WIDTH'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [C_CW-1:0]  r_cnt;
  logic [C_CW-1:0]  w_cnt_nxt;
  logic [WIDTH-1:0] r_din;
  logic [WIDTH-1:0] w_din_nxt;
  logic             w_done_nxt;

  logic             r_busy;
  logic             r_done;
  logic             r_cclr_bar;
  logic             r_cload_bar;
  logic             r_ccken;
  logic             r_rcken_bar;
  logic             r_g;
  logic             r_g_bar;
  logic [WIDTH-1:0] r_shadow;
  logic             r_wrap;
  logic             r_rco_err;

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_din   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_din   <= w_din_nxt;
    end
  end

  // Requests are only looked at in IDLE; the address is captured on acceptance.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_din_nxt   = r_din;
    case (r_state)
      S_IDLE: begin
        if (bus.clr_req) begin
          w_state_nxt = S_CLEAR;
        end else if (bus.jmp_req) begin
          w_state_nxt = S_LOADR;
          w_din_nxt   = bus.jmp_addr;
        end else if (bus.inc_req) begin
          w_state_nxt = S_INC;
        end
      end
      S_CLEAR, S_XFER, S_INC: begin
        w_state_nxt = S_SETTLE;
        w_cnt_nxt   = C_SETTLE_LAST;
      end
      S_LOADR: w_state_nxt = S_XFER;
      S_SETTLE: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - C_CW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_done_nxt = (w_state_nxt == S_SETTLE) && (w_cnt_nxt == '0);
  end

  // Controls are registered from the next state so each pin matches the state it belongs to.
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cclr_bar  <= 1'b0;
      r_cload_bar <= 1'b1;
      r_ccken     <= 1'b0;
      r_rcken_bar <= 1'b1;
      r_g         <= 1'b0;
      r_g_bar     <= 1'b1;
    end else begin
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= w_done_nxt;
      r_cclr_bar  <= (w_state_nxt != S_CLEAR);
      r_cload_bar <= (w_state_nxt != S_XFER);
      r_ccken     <= (w_state_nxt == S_INC);
      r_rcken_bar <= (w_state_nxt != S_LOADR);
      r_g         <= bus.oe_req;
      r_g_bar     <= ~bus.oe_req;
    end
  end

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      r_shadow  <= '0;
      r_wrap    <= 1'b0;
      r_rco_err <= 1'b0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_shadow <= '0;
          r_wrap   <= 1'b0;
        end
        S_XFER: begin
          r_shadow <= r_din;
          r_wrap   <= 1'b0;
        end
        S_INC: begin
          r_shadow <= r_shadow + C_ONE;
          if (&r_shadow) begin
            r_wrap <= 1'b1;
          end
        end
        default: ;
      endcase
      // The counter has settled whenever the sequencer is idle, so RCO must match.
      if ((r_state == S_IDLE) && !r_busy && (bus.ctr_rco_bar != ~&r_shadow)) begin
        r_rco_err <= 1'b1;
      end
    end
  end

  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.ctr_cclr_bar  = r_cclr_bar;
  assign bus.ctr_cload_bar = r_cload_bar;
  assign bus.ctr_ccken     = r_ccken;
  assign bus.ctr_rcken_bar = r_rcken_bar;
  assign bus.ctr_din       = r_din;
  assign bus.ctr_g         = r_g;
  assign bus.ctr_g_bar     = r_g_bar;
  assign bus.shadow_pc     = r_shadow;
  assign bus.wrap_flag     = r_wrap;
  assign bus.rco_err       = r_rco_err;

endmodule

`default_nettype wire

// File: tb/tb_pc_counter_sequencer.sv
// ------------------------------------------------------------------
// tb_pc_counter_sequencer: scoreboard bench with a behavioural counter chip.
// Rev 1.0
// ------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_pc_counter_sequencer;

  localparam int WIDTH   = 8;
  localparam int SETTLE  = 1;
  localparam int LAT_CLR = 2 + SETTLE;
  localparam int LAT_INC = 2 + SETTLE;
  localparam int LAT_JMP = 3 + SETTLE;

  logic clk = 1'b0;
  logic reset_bar = 1'b1;

  pc_counter_sequencer_if #(.WIDTH(WIDTH)) bus();

  pc_counter_sequencer #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
    .clk       (clk),
    .reset_bar (reset_bar),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural counter chip: register input, clear/load/count, ripple carry.
  logic [7:0] m_reg = 8'h00;
  logic [7:0] m_q   = 8'h00;
  logic       force_rco = 1'b0;
  always @(posedge clk) begin
    if (!bus.ctr_rcken_bar) m_reg <= bus.ctr_din;
    if (!bus.ctr_cclr_bar)       m_q <= 8'h00;
    else if (!bus.ctr_cload_bar) m_q <= m_reg;
    else if (bus.ctr_ccken)      m_q <= m_q + 8'h01;
  end
  assign bus.ctr_rco_bar = force_rco ? 1'b0 : ~&m_q;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int         dcyc;
    logic [7:0] pc;
    logic       wrap;
    logic       rco;
    logic [7:0] q;
  } exp_t;
  exp_t sbq[$];

  logic [7:0] m_pc   = 8'h00;
  logic       m_wrap = 1'b0;
  logic       m_rco  = 1'b0;
  logic [7:0] exp_din = 8'h00;

  task automatic push(input int dcyc);
    exp_t e;
    e.dcyc = dcyc; e.pc = m_pc; e.wrap = m_wrap; e.rco = m_rco; e.q = m_pc;
    sbq.push_back(e);
  endtask

  task automatic model_inc();
    if (m_pc == 8'hFF) m_wrap = 1'b1;
    m_pc = m_pc + 8'h01;
  endtask

  // Monitor: scoreboard pops on done, plus per-cycle pin checks.
  exp_t me;
  int run_ccken = 0, run_rcken = 0, run_cload = 0, run_cclr = 0;
  logic cclr_from_rst = 1'b1;
  always @(negedge clk) begin
    if (!reset_bar) begin
      run_ccken = 0; run_rcken = 0; run_cload = 0; run_cclr = 0;
      cclr_from_rst = 1'b1;
    end else begin
      if (bus.done) begin
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: got done=1 expected none (cyc %0d)", cyc);
        end else begin
          me = sbq.pop_front();
          chk("done_cycle", 32'(cyc), 32'(me.dcyc));
          chk("shadow_pc", 32'(bus.shadow_pc), 32'(me.pc));
          chk("wrap_flag", 32'(bus.wrap_flag), 32'(me.wrap));
          chk("rco_err", 32'(bus.rco_err), 32'(me.rco));
          chk("counter_q", 32'(m_q), 32'(me.q));
          chk("busy_at_done", 32'(bus.busy), 32'd1);
        end
      end
      chk("ctrl_exclusive", 32'((32'(!bus.ctr_cclr_bar) + 32'(!bus.ctr_cload_bar) +
          32'(bus.ctr_ccken) + 32'(!bus.ctr_rcken_bar)) <= 32'd1), 32'd1);
      if (!bus.ctr_cload_bar || !bus.ctr_rcken_bar) chk("ctr_din", 32'(bus.ctr_din), 32'(exp_din));
      if (bus.ctr_ccken) run_ccken++;
      else if (run_ccken != 0) begin chk("ccken_width", 32'(run_ccken), 32'd1); run_ccken = 0; end
      if (!bus.ctr_rcken_bar) run_rcken++;
      else if (run_rcken != 0) begin chk("rcken_width", 32'(run_rcken), 32'd1); run_rcken = 0; end
      if (!bus.ctr_cload_bar) run_cload++;
      else if (run_cload != 0) begin chk("cload_width", 32'(run_cload), 32'd1); run_cload = 0; end
      if (!bus.ctr_cclr_bar) run_cclr++;
      else begin
        if (run_cclr != 0 && !cclr_from_rst) chk("cclr_width", 32'(run_cclr), 32'd1);
        run_cclr = 0;
        cclr_from_rst = 1'b0;
      end
    end
  end

  task automatic wait_done(input int n);
    int seen = 0;
    int t = 0;
    while (seen < n && t < 100) begin
      @(negedge clk);
      t++;
      if (bus.done) seen++;
    end
    if (seen < n) begin
      total++; bad++;
      $display("FAIL done_timeout: got %0d dones expected %0d", seen, n);
    end
  endtask

  // kind: 0 clear, 1 jump, 2 increment
  task automatic op(input int kind, input logic [7:0] a);
    int c;
    @(negedge clk);
    c = cyc;
    case (kind)
      0: begin m_pc = 8'h00; m_wrap = 1'b0; push(c + LAT_CLR - 1); bus.clr_req = 1'b1; end
      1: begin m_pc = a; m_wrap = 1'b0; exp_din = a; push(c + LAT_JMP - 1);
               bus.jmp_addr = a; bus.jmp_req = 1'b1; end
      default: begin model_inc(); push(c + LAT_INC - 1); bus.inc_req = 1'b1; end
    endcase
    @(posedge clk);
    #1 bus.jmp_addr = ~a;
    wait_done(1);
    bus.clr_req = 1'b0; bus.jmp_req = 1'b0; bus.inc_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    bus.clr_req = 1'b0; bus.jmp_req = 1'b0; bus.inc_req = 1'b0;
    bus.oe_req = 1'b0; bus.jmp_addr = 8'h00;
    #2 reset_bar = 1'b0;
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_cclr_bar", 32'(bus.ctr_cclr_bar), 32'd0);
    chk("rst_cload_bar", 32'(bus.ctr_cload_bar), 32'd1);
    chk("rst_ccken", 32'(bus.ctr_ccken), 32'd0);
    chk("rst_rcken_bar", 32'(bus.ctr_rcken_bar), 32'd1);
    chk("rst_din", 32'(bus.ctr_din), 32'd0);
    chk("rst_shadow", 32'(bus.shadow_pc), 32'd0);
    chk("rst_wrap", 32'(bus.wrap_flag), 32'd0);
    chk("rst_rco_err", 32'(bus.rco_err), 32'd0);
    chk("rst_g", 32'(bus.ctr_g), 32'd0);
    chk("rst_g_bar", 32'(bus.ctr_g_bar), 32'd1);
    repeat (3) @(negedge clk);
    reset_bar = 1'b1;

    // Output enable is a registered copy of oe_req.
    @(negedge clk);
    bus.oe_req = 1'b1;
    #1 chk("g_registered", 32'(bus.ctr_g), 32'd0);
    @(negedge clk);
    chk("g_on", 32'(bus.ctr_g), 32'd1);
    chk("g_bar_on", 32'(bus.ctr_g_bar), 32'd0);
    bus.oe_req = 1'b0;
    @(negedge clk);
    chk("g_off", 32'(bus.ctr_g), 32'd0);
    chk("g_bar_off", 32'(bus.ctr_g_bar), 32'd1);

    // Increment held through three operations; each re-accepted after done.
    @(negedge clk);
    c = cyc;
    model_inc(); push(c + LAT_INC - 1);
    model_inc(); push(c + 2 * LAT_INC - 1);
    model_inc(); push(c + 3 * LAT_INC - 1);
    bus.inc_req = 1'b1;
    wait_done(3);
    bus.inc_req = 1'b0;

    // Jump, then wrap through all-ones, then clear.
    op(1, 8'hA5);
    op(1, 8'hFE);
    op(2, 8'h00);
    op(2, 8'h00);
    op(0, 8'h00);

    // Simultaneous requests: clear, then jump, then increment, each held until its done.
    @(negedge clk);
    c = cyc;
    m_pc = 8'h00; m_wrap = 1'b0; push(c + LAT_CLR - 1);
    m_pc = 8'h3C; exp_din = 8'h3C; push(c + LAT_CLR - 1 + LAT_JMP);
    model_inc(); push(c + LAT_CLR - 1 + LAT_JMP + LAT_INC);
    bus.jmp_addr = 8'h3C;
    bus.clr_req = 1'b1; bus.jmp_req = 1'b1; bus.inc_req = 1'b1;
    wait_done(1); bus.clr_req = 1'b0;
    wait_done(1); bus.jmp_req = 1'b0;
    wait_done(1); bus.inc_req = 1'b0;

    // RCO disagreement while idle sets the sticky error.
    op(1, 8'h10);
    @(negedge clk);
    chk("rco_err_clean", 32'(bus.rco_err), 32'd0);
    force_rco = 1'b1;
    @(negedge clk);
    force_rco = 1'b0;
    m_rco = 1'b1;
    chk("rco_err_set", 32'(bus.rco_err), 32'd1);
    op(2, 8'h00);
    chk("rco_err_sticky", 32'(bus.rco_err), 32'd1);

    // Reset during XFER aborts without done.
    @(negedge clk);
    c = cyc;
    exp_din = 8'h77;
    bus.jmp_addr = 8'h77;
    bus.jmp_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("in_xfer", 32'(bus.ctr_cload_bar), 32'd0);
    reset_bar = 1'b0;
    bus.jmp_req = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_shadow", 32'(bus.shadow_pc), 32'd0);
    chk("abort_cclr_bar", 32'(bus.ctr_cclr_bar), 32'd0);
    chk("abort_rco_err", 32'(bus.rco_err), 32'd0);
    m_pc = 8'h00; m_wrap = 1'b0; m_rco = 1'b0;
    repeat (2) @(negedge clk);
    reset_bar = 1'b1;
    repeat (4) @(negedge clk);
    op(2, 8'h00);
    chk("post_reset_pc", 32'(bus.shadow_pc), 32'd1);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
